sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: NPORT, 2, number of requesters; fixed at 2 in this revision.
REQ-002 clk_100m  in  1  single clock for all logic.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cli_req  in  2  per-port transfer request; level, held until cli_done.
REQ-005 cli_we  in  2  per-port direction: 1 write, 0 read.
REQ-006 cli_addr  in  48  per-port 24-bit word address; port p at [24p+23:24p].
REQ-007 cli_len  in  18  per-port 9-bit burst length in words; port p at [9p+8:9p].
REQ-008 cli_wdata  in  32  per-port 16-bit write data; port p at [16p+15:16p].
REQ-009 cli_ack  out  2  per-port data strobe, one word per high cycle.
REQ-010 cli_done  out  2  per-port one-cycle end-of-transfer pulse.
REQ-011 cli_rdata  out  16  read data, broadcast to all ports.
REQ-012 sdram_wr_req, sdram_rd_req  out  1 each  requests to the SDRAM controller.
REQ-013 sdram_wr_addr, sdram_rd_addr  out  24 each  controller addresses.
REQ-014 sdwr_bytes, sdrd_bytes  out  9 each  controller burst lengths.
REQ-015 sdram_wr_data  out  16  write data to the controller.
REQ-016 sdram_wr_ack, sdram_rd_ack  in  1 each  controller per-word strobes.
REQ-017 sdram_rd_data  in  16  controller read data.
REQ-018 sdram_init_done, sdram_busy  in  1 each  controller status.

Function
REQ-019 FSM states: IDLE, REQ, XFER, DONE.
REQ-020 IDLE->REQ: only when sdram_init_done=1, sdram_busy=0 and cli_req!=0; winner g is latched as grant, together with cli_we[g], cli_addr[g] and cli_len[g].
REQ-021 Arbitration is round-robin: the port other than last_grant wins if it requests; otherwise the requesting port wins.
REQ-022 Latched length 0 is treated as 1; the latched address and length are held stable for the whole transfer.
REQ-023 In REQ and XFER, the arbiter drives sdram_wr_req (we=1) or sdram_rd_req (we=0) high from the latched fields; the other request stays 0.
REQ-024 REQ->XFER on the first cycle the matching controller ack is high.
REQ-025 A 9-bit word counter increments on each matching ack cycle.
REQ-026 XFER->DONE on the ack cycle where the counter reaches the latched length; the request is deasserted from DONE onward.
REQ-027 cli_ack[grant] is a combinational copy of the matching controller ack; the non-granted cli_ack bit is always 0.
REQ-028 sdram_wr_data is a combinational mux of cli_wdata[grant]; cli_rdata equals sdram_rd_data.
REQ-029 In DONE, cli_done[grant] pulses for 1 cycle, last_grant is set to grant, and the FSM returns to IDLE; a new grant occurs no earlier than the next cycle.
REQ-030 Changes to cli_req, address or length of a port during its own grant are ignored until DONE.
REQ-031 A non-granted port dropping its request has no effect; the granted port dropping its request does not abort the burst.
REQ-032 Acks of the opposite direction are ignored.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE; all requests, cli_ack and cli_done 0; addresses, lengths and counter 0; grant=0; last_grant=1, so port 0 wins first.
REQ-034 Reset mid-burst abandons the burst; no cli_done is issued.

Configuration
REQ-035 SDRAM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins simultaneous requests and last_grant is unused; when undefined, round-robin per REQ-021 applies.

Verification
REQ-036 init_done=0, port0 requests a read, len 4 -> no sdram_rd_req until init_done=1; then rd_req=1 with addr equal to port0 addr and sdrd_bytes=4.
REQ-037 Port1 writes len 3 at 0x000100 with data A,B,C, controller acks 3 cycles -> sdram_wr_data = A,B,C on those cycles, cli_done[1] pulses exactly once, one cycle after the last ack.
REQ-038 Both ports request continuously with len 1 (round-robin build) -> grants 0,1,0,1; with SDRAM_ARB_FIXED_PRIO_EN -> grants 0,0,0.
REQ-039 sdram_busy=1 while requests are pending -> state stays IDLE with no request output; grant occurs the cycle after busy falls.
REQ-040 rst_n low after 2 of 8 read acks -> outputs 0 immediately, no cli_done; the first grant after reset goes to port 0.
REQ-041 Port0 len 0 read -> sdrd_bytes=1, single ack, cli_done[0] pulses.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - client and SDRAM-controller signal bundle for sdram_arbiter
interface sdram_arbiter_if;
    logic [1:0]  cli_req;
    logic [1:0]  cli_we;
    logic [47:0] cli_addr;
    logic [17:0] cli_len;
    logic [31:0] cli_wdata;
    logic [1:0]  cli_ack;
    logic [1:0]  cli_done;
    logic [15:0] cli_rdata;

    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [23:0] sdram_wr_addr;
    logic [23:0] sdram_rd_addr;
    logic [8:0]  sdwr_bytes;
    logic [8:0]  sdrd_bytes;
    logic [15:0] sdram_wr_data;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic [15:0] sdram_rd_data;
    logic        sdram_init_done;
    logic        sdram_busy;

    // Arbiter side
    modport master (
        input  cli_req, cli_we, cli_addr, cli_len, cli_wdata,
        output cli_ack, cli_done, cli_rdata,
        output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
        output sdwr_bytes, sdrd_bytes, sdram_wr_data,
        input  sdram_wr_ack, sdram_rd_ack, sdram_rd_data, sdram_init_done, sdram_busy
    );

    // Clients plus controller side
    modport slave (
        output cli_req, cli_we, cli_addr, cli_len, cli_wdata,
        input  cli_ack, cli_done, cli_rdata,
        input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
        input  sdwr_bytes, sdrd_bytes, sdram_wr_data,
        output sdram_wr_ack, sdram_rd_ack, sdram_rd_data, sdram_init_done, sdram_busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM burst arbiter, round-robin by default
// Define SDRAM_ARB_FIXED_PRIO_EN to make port 0 win every simultaneous request.
module sdram_arbiter #(
    parameter int NPORT = 2
) (
    input  logic           clk_100m,
    input  logic           rst_n,
    sdram_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t           state;
    logic             grant;
    logic             last_grant;
    logic             we_l;
    logic [23:0]      addr_l;
    logic [8:0]       len_l;
    logic [8:0]       cnt;
    logic             wr_req;
    logic             rd_req;
    logic [NPORT-1:0] done;

    logic             active;
    logic             hit;
    logic             win;
    logic [8:0]       win_len;
    logic [8:0]       cnt_next;

    assign active   = (state == REQ) || (state == XFER);
    // Only the ack matching the latched direction counts as a word.
    assign hit      = active && (we_l ? bus.sdram_wr_ack : bus.sdram_rd_ack);
    assign cnt_next = cnt + 9'd1;

    always_comb begin
        win = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        win = bus.cli_req[0] ? 1'b0 : 1'b1;
`else
        win = bus.cli_req[~last_grant] ? ~last_grant : last_grant;
`endif
    end

    assign win_len = win ? bus.cli_len[17:9] : bus.cli_len[8:0];

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_l       <= 1'b0;
            addr_l     <= '0;
            len_l      <= '0;
            cnt        <= '0;
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            done       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (bus.sdram_init_done && !bus.sdram_busy && (bus.cli_req != 2'b00)) begin
                        grant  <= win;
                        we_l   <= bus.cli_we[win];
                        addr_l <= win ? bus.cli_addr[47:24] : bus.cli_addr[23:0];
                        len_l  <= (win_len == 9'd0) ? 9'd1 : win_len;
                        cnt    <= '0;
                        wr_req <= bus.cli_we[win];
                        rd_req <= ~bus.cli_we[win];
                        state  <= REQ;
                    end
                end
                REQ, XFER: begin
                    if (hit) begin
                        cnt <= cnt_next;
                        if (cnt_next >= len_l) begin
                            wr_req      <= 1'b0;
                            rd_req      <= 1'b0;
                            done[grant] <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                DONE: begin
                    done       <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdram_wr_req  = wr_req;
    assign bus.sdram_rd_req  = rd_req;
    assign bus.sdram_wr_addr = addr_l;
    assign bus.sdram_rd_addr = addr_l;
    assign bus.sdwr_bytes    = len_l;
    assign bus.sdrd_bytes    = len_l;
    assign bus.sdram_wr_data = grant ? bus.cli_wdata[31:16] : bus.cli_wdata[15:0];
    assign bus.cli_rdata     = bus.sdram_rd_data;
    assign bus.cli_ack       = {grant & hit, ~grant & hit};
    assign bus.cli_done      = done;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
    logic clk_100m = 1'b0;
    logic rst_n    = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    sdram_arbiter_if bus();

    sdram_arbiter #(.NPORT(2)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input bit wr);
        int n = 0;
        while (!(wr ? bus.sdram_wr_req : bus.sdram_rd_req) && n < 20) begin
            @(negedge clk_100m);
            #1;
            n++;
        end
        check("wait_req", 48'(n < 20), 48'd1);
    endtask

    logic [15:0] wd [3];
    logic [1:0]  exp_g;
    logic        seen;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wd[0] = 16'hAAAA; wd[1] = 16'hBBBB; wd[2] = 16'hCCCC;
        bus.cli_req = '0; bus.cli_we = '0; bus.cli_addr = '0; bus.cli_len = '0;
        bus.cli_wdata = '0; bus.sdram_wr_ack = 0; bus.sdram_rd_ack = 0;
        bus.sdram_rd_data = '0; bus.sdram_init_done = 0; bus.sdram_busy = 0;
        repeat (3) @(negedge clk_100m);
        #1;
        check("rst_rd_req", bus.sdram_rd_req, 0);
        check("rst_wr_req", bus.sdram_wr_req, 0);
        check("rst_done", bus.cli_done, 0);
        check("rst_bytes", bus.sdrd_bytes, 0);
        rst_n = 1;

        // Read held off until init_done
        bus.cli_req[0] = 1; bus.cli_we[0] = 0;
        bus.cli_addr[23:0] = 24'h123456; bus.cli_len[8:0] = 9'd4;
        seen = 0;
        repeat (5) begin
            @(negedge clk_100m); #1;
            seen = seen | bus.sdram_rd_req | bus.sdram_wr_req;
        end
        check("no_req_before_init", seen, 0);
        bus.sdram_init_done = 1;
        @(negedge clk_100m); #1;
        check("init_rd_req", bus.sdram_rd_req, 1);
        check("init_wr_req", bus.sdram_wr_req, 0);
        check("init_rd_addr", bus.sdram_rd_addr, 24'h123456);
        check("init_bytes", bus.sdrd_bytes, 4);
        for (int i = 0; i < 4; i++) begin
            bus.sdram_rd_ack = 1; bus.sdram_rd_data = 16'hA000 + 16'(i);
            #1;
            check("rd_cli_ack", bus.cli_ack, 2'b01);
            check("rd_cli_rdata", bus.cli_rdata, 16'hA000 + 16'(i));
            @(negedge clk_100m); #1;
        end
        bus.sdram_rd_ack = 0;
        check("rd_done", bus.cli_done, 2'b01);
        check("rd_req_off", bus.sdram_rd_req, 0);
        bus.cli_req[0] = 0;
        @(negedge clk_100m); #1;
        check("rd_done_clear", bus.cli_done, 0);

        // Port 1 three-word write
        bus.cli_req[1] = 1; bus.cli_we[1] = 1;
        bus.cli_addr[47:24] = 24'h000100; bus.cli_len[17:9] = 9'd3;
        wait_req(1);
        check("wr_addr", bus.sdram_wr_addr, 24'h000100);
        check("wr_bytes", bus.sdwr_bytes, 3);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            bus.cli_wdata[31:16] = wd[i]; bus.sdram_wr_ack = 1;
            #1;
            check("wr_data", bus.sdram_wr_data, wd[i]);
            check("wr_cli_ack", bus.cli_ack, 2'b10);
            seen = seen | (bus.cli_done != 0);
            @(negedge clk_100m); #1;
        end
        bus.sdram_wr_ack = 0;
        check("wr_done_early", seen, 0);
        check("wr_done", bus.cli_done, 2'b10);
        bus.cli_req[1] = 0;
        @(negedge clk_100m); #1;
        check("wr_done_once", bus.cli_done, 0);

        // Both ports request continuously, length 1
        bus.cli_req = 2'b11; bus.cli_we = 2'b00; bus.cli_len = {9'd1, 9'd1};
        bus.cli_addr = {24'h000020, 24'h000010};
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            wait_req(0);
            bus.sdram_rd_ack = 1;
            #1;
            check("arb_grant", bus.cli_ack, exp_g);
            @(negedge clk_100m); #1;
            bus.sdram_rd_ack = 0;
            check("arb_done", bus.cli_done, exp_g);
        end
        bus.cli_req = 2'b00;
        @(negedge clk_100m); #1;

        // Busy holds off the grant; opposite-direction ack ignored
        bus.sdram_busy = 1;
        bus.cli_req[0] = 1; bus.cli_we[0] = 0;
        bus.cli_addr[23:0] = 24'h000055; bus.cli_len[8:0] = 9'd2;
        seen = 0;
        repeat (4) begin
            @(negedge clk_100m); #1;
            seen = seen | bus.sdram_rd_req | bus.sdram_wr_req;
        end
        check("busy_no_req", seen, 0);
        bus.sdram_busy = 0;
        @(negedge clk_100m); #1;
        check("busy_grant", bus.sdram_rd_req, 1);
        bus.sdram_wr_ack = 1;
        #1;
        check("opp_ack", bus.cli_ack, 2'b00);
        @(negedge clk_100m); #1;
        bus.sdram_wr_ack = 0;
        check("opp_ack_req", bus.sdram_rd_req, 1);
        repeat (2) begin
            bus.sdram_rd_ack = 1;
            @(negedge clk_100m); #1;
        end
        bus.sdram_rd_ack = 0;
        check("busy_done", bus.cli_done, 2'b01);
        bus.cli_req = 2'b00;
        @(negedge clk_100m); #1;

        // Reset in the middle of an 8-word read
        bus.cli_req[1] = 1; bus.cli_we[1] = 0;
        bus.cli_addr[47:24] = 24'h000777; bus.cli_len[17:9] = 9'd8;
        wait_req(0);
        repeat (2) begin
            bus.sdram_rd_ack = 1;
            @(negedge clk_100m); #1;
        end
        bus.cli_req = 2'b11; bus.cli_len[8:0] = 9'd1; bus.cli_addr[23:0] = 24'h000010;
        #1 rst_n = 0;
        #1;
        check("mid_rst_req", bus.sdram_rd_req, 0);
        check("mid_rst_ack", bus.cli_ack, 0);
        check("mid_rst_bytes", bus.sdrd_bytes, 0);
        check("mid_rst_done", bus.cli_done, 0);
        bus.sdram_rd_ack = 0;
        @(negedge clk_100m);
        rst_n = 1;
        wait_req(0);
        bus.sdram_rd_ack = 1;
        #1;
        check("post_rst_grant", bus.cli_ack, 2'b01);
        @(negedge clk_100m); #1;
        bus.sdram_rd_ack = 0;
        check("post_rst_done", bus.cli_done, 2'b01);
        bus.cli_req = 2'b00;
        @(negedge clk_100m); #1;
        @(negedge clk_100m); #1;

        // Zero length behaves as one word
        bus.cli_req[0] = 1; bus.cli_we[0] = 0;
        bus.cli_addr[23:0] = 24'h000042; bus.cli_len[8:0] = 9'd0;
        wait_req(0);
        check("len0_bytes", bus.sdrd_bytes, 1);
        bus.sdram_rd_ack = 1;
        @(negedge clk_100m); #1;
        bus.sdram_rd_ack = 0;
        check("len0_done", bus.cli_done, 2'b01);
        check("len0_req_off", bus.sdram_rd_req, 0);
        bus.cli_req = 2'b00;
        @(negedge clk_100m); #1;
        check("len0_done_once", bus.cli_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
